// File: rtl/tt_um_mag_iter.sv
// ---------------------------------------------------------------------------
// tt_um_mag_iter -- iterative magnitude responder
//
// Computes |(X,Y)| = sqrt(X^2 + Y^2) for two 8-bit unsigned operands using
// one shared squaring stage followed by a 9-step restoring digit-by-digit
// integer square root (one result bit per cycle, MSB first).
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   ena      in   tile enable; 0 freezes every register
//   ui_in    in   operand data byte
//   uio_in   in   [0] load strobe, [1] operand select (0=X,1=Y), [2] start
//   uo_out   out  result[7:0]
//   uio_out  out  [4] busy, [5] done, [6] result[8], other bits 0
//   uio_oe   out  constant 8'b0111_0000
//
// Optional feature macro: MAG_ROUND_EN
//   defined   -> extra ROUND cycle, round-to-nearest result (0..361), latency 12
//   undefined -> floor result (0..360), latency 11
// ---------------------------------------------------------------------------
module tt_um_mag_iter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int DATA_W = 8;
    localparam int ACC_W  = 17;
    localparam int ROOT_W = 9;

`ifdef MAG_ROUND_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SQX   = 3'd1,
        S_SQY   = 3'd2,
        S_ROOT  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SQX   = 3'd1,
        S_SQY   = 3'd2,
        S_ROOT  = 3'd3,
        S_DONE  = 3'd5
    } state_t;
`endif

    // Host strobes
    logic load_s;
    logic sel_s;
    logic start_s;

    assign load_s  = uio_in[0];
    assign sel_s   = uio_in[1];
    assign start_s = uio_in[2];

    // Bits [7:3] of uio_in carry no function
    logic unused_uio;
    assign unused_uio = &{1'b0, uio_in[7:3]};

    // State and datapath registers
    state_t              state_q, state_d;
    logic [DATA_W-1:0]   opx_q, opx_d;
    logic [DATA_W-1:0]   opy_q, opy_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ROOT_W-1:0]   root_q, root_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ROOT_W-1:0]   res_q, res_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

`ifdef MAG_ROUND_EN
    // Round-to-nearest correction: with rem = N - r^2, the value N is closer
    // to (r+1)^2 than to r^2 exactly when rem > r (since (r+0.5)^2 = r^2+r+0.25).
    function automatic logic [ROOT_W-1:0] round_nearest(input logic [ROOT_W-1:0] r,
                                                        input logic [ACC_W-1:0]  rem);
        if (rem > {{(ACC_W-ROOT_W){1'b0}}, r})
            return r + {{(ROOT_W-1){1'b0}}, 1'b1};
        else
            return r;
    endfunction
`endif

    // One shared squarer: X during SQX, Y otherwise (only SQY uses it then)
    logic [DATA_W-1:0]   sq_op;
    logic [2*DATA_W-1:0] sq;

    assign sq_op = (state_q == S_SQX) ? opx_q : opy_q;
    assign sq    = {{DATA_W{1'b0}}, sq_op} * {{DATA_W{1'b0}}, sq_op};

    // Restoring root step for bit i = cnt_q. The remainder acc holds
    // N - root^2; setting bit i costs (root << (i+1)) + (1 << 2i), i.e.
    // (root + 2^i)^2 - root^2. Root only has bits above i here, so the
    // trial value stays well inside 18 bits.
    logic [ACC_W:0]      trial;
    logic                trial_ok;
    logic [ROOT_W-1:0]   root_step;
    logic [ACC_W-1:0]    acc_step;

    always_comb begin
        trial     = ({{(ACC_W+1-ROOT_W){1'b0}}, root_q} << ({1'b0, cnt_q} + 5'd1))
                  + ({{ACC_W{1'b0}}, 1'b1} << {cnt_q, 1'b0});
        trial_ok  = ({1'b0, acc_q} >= trial);
        root_step = root_q;
        acc_step  = acc_q;
        if (trial_ok) begin
            root_step = root_q | ({{(ROOT_W-1){1'b0}}, 1'b1} << cnt_q);
            acc_step  = acc_q - trial[ACC_W-1:0];
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        opx_d   = opx_q;
        opy_d   = opy_q;
        acc_d   = acc_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        busy_d  = busy_q;
        done_d  = done_q;

        // Operands are writable only while no computation is in flight
        if ((state_q == S_IDLE || state_q == S_DONE) && load_s) begin
            if (sel_s)
                opy_d = ui_in;
            else
                opx_d = ui_in;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_s) begin
                    state_d = S_SQX;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end

            S_SQX: begin
                acc_d   = {1'b0, sq};
                state_d = S_SQY;
            end

            S_SQY: begin
                // 255^2 + 255^2 = 130050 fits in 17 bits
                acc_d   = acc_q + {1'b0, sq};
                root_d  = '0;
                cnt_d   = 4'd8;
                state_d = S_ROOT;
            end

            S_ROOT: begin
                root_d = root_step;
                acc_d  = acc_step;
                if (cnt_q == 4'd0) begin
`ifdef MAG_ROUND_EN
                    state_d = S_ROUND;
`else
                    state_d = S_DONE;
                    res_d   = root_step;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

`ifdef MAG_ROUND_EN
            S_ROUND: begin
                res_d   = round_nearest(root_q, acc_q);
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
`endif

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State register: ena low holds every register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            opx_q   <= '0;
            opy_q   <= '0;
            acc_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            opx_q   <= opx_d;
            opy_q   <= opy_d;
            acc_q   <= acc_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Outputs
    assign uo_out  = res_q[7:0];
    assign uio_out = {1'b0, res_q[8], done_q, busy_q, 4'b0000};
    assign uio_oe  = 8'b0111_0000;

endmodule

// File: tb/tb_tt_um_mag_iter.sv
// Directed bench for tt_um_mag_iter. Expected values are hand-computed
// floor / round-to-nearest magnitudes for each operand pair.
module tb_tt_um_mag_iter;

`ifdef MAG_ROUND_EN
    localparam int LAT = 12;
`else
    localparam int LAT = 11;
`endif

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;
    logic [8:0] prev_res;

    tt_um_mag_iter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers (no checking inside)
    task automatic do_load(input logic sel, input logic [7:0] v);
        ui_in  = v;
        uio_in = {5'b00000, sel, 1'b1};
        @(negedge clk);
        uio_in = 8'h00;
    endtask

    task automatic do_start();
        uio_in = 8'h04;
        @(negedge clk);
        uio_in = 8'h00;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        prev_res = 9'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uo_out got %h want 00", uo_out);
        end
        checks++;
        if (uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uio_out got %h want 00", uio_out);
        end
        checks++;
        if (uio_oe !== 8'h70) begin
            errors++;
            $display("FAIL reset_uio_oe got %h want 70", uio_oe);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [7:0] xs [7] = '{8'd3, 8'd255, 8'd2, 8'd0, 8'd1, 8'd100, 8'd8};
        logic [7:0] ys [7] = '{8'd4, 8'd255, 8'd3, 8'd0, 8'd1, 8'd200, 8'd15};
        logic [8:0] ef [7] = '{9'd5, 9'd360, 9'd3, 9'd0, 9'd1, 9'd223, 9'd17};
        logic [8:0] er [7] = '{9'd5, 9'd361, 9'd4, 9'd0, 9'd1, 9'd224, 9'd17};
        logic [8:0] exp;
        for (int v = 0; v < 7; v++) begin
`ifdef MAG_ROUND_EN
            exp = er[v];
`else
            exp = ef[v];
`endif
            do_load(1'b0, xs[v]);
            do_load(1'b1, ys[v]);
            do_start();
            // Now past the start edge k; busy for LAT edges
            for (int c = 0; c < LAT; c++) begin
                checks++;
                if (uio_out !== {1'b0, prev_res[8], 2'b01, 4'b0000} || uo_out !== prev_res[7:0]) begin
                    errors++;
                    $display("FAIL vec%0d_busy_c%0d got uo=%h uio=%h want uo=%h uio=%h",
                             v, c, uo_out, uio_out, prev_res[7:0], {1'b0, prev_res[8], 2'b01, 4'b0000});
                end
                @(negedge clk);
            end
            checks++;
            if (uo_out !== exp[7:0] || uio_out !== {1'b0, exp[8], 2'b10, 4'b0000}) begin
                errors++;
                $display("FAIL vec%0d_done x=%0d y=%0d got uo=%h uio=%h want uo=%h uio=%h",
                         v, xs[v], ys[v], uo_out, uio_out, exp[7:0], {1'b0, exp[8], 2'b10, 4'b0000});
            end
            prev_res = exp;
            // Result stays stable in DONE
            @(negedge clk);
            checks++;
            if (uo_out !== exp[7:0] || uio_out !== {1'b0, exp[8], 2'b10, 4'b0000}) begin
                errors++;
                $display("FAIL vec%0d_hold got uo=%h uio=%h want uo=%h", v, uo_out, uio_out, exp[7:0]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        // X=3,Y=4 then a stray load X=FF + start while busy
        do_load(1'b0, 8'd3);
        do_load(1'b1, 8'd4);
        do_start();
        for (int c = 0; c < LAT; c++) begin
            if (c == 2) begin
                ui_in  = 8'hFF;
                uio_in = 8'h05;
            end else begin
                uio_in = 8'h00;
            end
            checks++;
            if (uio_out[5:4] !== 2'b01) begin
                errors++;
                $display("FAIL ignore_busy_c%0d got %b want 01", c, uio_out[5:4]);
            end
            @(negedge clk);
        end
        uio_in = 8'h00;
        checks++;
        if (uo_out !== 8'h05 || uio_out !== 8'h20) begin
            errors++;
            $display("FAIL ignore_result got uo=%h uio=%h want uo=05 uio=20", uo_out, uio_out);
        end
        // Restart without loading: X must still be 3
        do_start();
        repeat (LAT) @(negedge clk);
        checks++;
        if (uo_out !== 8'h05 || uio_out !== 8'h20) begin
            errors++;
            $display("FAIL ignore_opx_kept got uo=%h uio=%h want uo=05 uio=20", uo_out, uio_out);
        end
        // Load X=6 and start on the same edge: sqrt(36+16) = 7.2 -> 7 both builds
        ui_in  = 8'd6;
        uio_in = 8'h05;
        @(negedge clk);
        uio_in = 8'h00;
        repeat (LAT - 1) @(negedge clk);
        checks++;
        if (uio_out[5] !== 1'b0) begin
            errors++;
            $display("FAIL same_edge_early_done got done=%b want 0", uio_out[5]);
        end
        @(negedge clk);
        checks++;
        if (uo_out !== 8'h07 || uio_out !== 8'h20) begin
            errors++;
            $display("FAIL same_edge_load got uo=%h uio=%h want uo=07 uio=20", uo_out, uio_out);
        end
        prev_res = 9'd7;
    endtask

    task automatic test_ena_stall();
        logic [8:0] exp;
`ifdef MAG_ROUND_EN
        exp = 9'd224;
`else
        exp = 9'd223;
`endif
        do_load(1'b0, 8'd100);
        do_load(1'b1, 8'd200);
        do_start();
        // Edges k+5..k+9 are frozen (mid-ROOT)
        for (int c = 1; c <= LAT + 5; c++) begin
            ena = (c >= 5 && c <= 9) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (c < LAT + 5) begin
                checks++;
                if (uio_out[5:4] !== 2'b01 || uo_out !== prev_res[7:0]) begin
                    errors++;
                    $display("FAIL stall_busy_c%0d got status=%b uo=%h want status=01 uo=%h",
                             c, uio_out[5:4], uo_out, prev_res[7:0]);
                end
            end
        end
        ena = 1'b1;
        checks++;
        if (uo_out !== exp[7:0] || uio_out !== {1'b0, exp[8], 2'b10, 4'b0000}) begin
            errors++;
            $display("FAIL stall_done got uo=%h uio=%h want uo=%h uio=%h",
                     uo_out, uio_out, exp[7:0], {1'b0, exp[8], 2'b10, 4'b0000});
        end
        prev_res = exp;
    endtask

    task automatic test_reset_mid();
        do_load(1'b0, 8'd255);
        do_load(1'b1, 8'd255);
        do_start();
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h70) begin
            errors++;
            $display("FAIL reset_mid got uo=%h uio=%h oe=%h want 00 00 70", uo_out, uio_out, uio_oe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        prev_res = 9'd0;
        // Fresh computation after reset: 8,15 -> 17
        do_load(1'b0, 8'd8);
        do_load(1'b1, 8'd15);
        do_start();
        checks++;
        if (uio_out !== 8'h10 || uo_out !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_busy got uo=%h uio=%h want uo=00 uio=10", uo_out, uio_out);
        end
        repeat (LAT) @(negedge clk);
        checks++;
        if (uo_out !== 8'd17 || uio_out !== 8'h20) begin
            errors++;
            $display("FAIL post_reset_result got uo=%h uio=%h want uo=11 uio=20", uo_out, uio_out);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_busy_ignore();
        test_ena_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
